// File: rtl/avalon_wr_sink_pkg.sv
// Shared constants, framing state and FIFO entry layout for avalon_wr_sink.
package avalon_wr_sink_pkg;

    localparam int ADDR_W        = 17;
    localparam int WDATA_W       = 521;
    localparam int DATA_W        = 512;
    localparam int EMPTY_W       = 6;

    localparam int SOP_BIT       = 512;
    localparam int EOP_BIT       = 513;
    localparam int EMPTY_LSB     = 514;
    localparam int CTRL_ADDR_BIT = 16;

    // Control-window command bits within writedata.
    localparam int CTRL_CLR_BIT  = 0;
    localparam int CTRL_IDLE_BIT = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } frame_state_e;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } fifo_entry_t;

endpackage

// File: rtl/avalon_wr_sink_if.sv
// Avalon-MM write port (topA_*) between the write service master and the sink.
interface avalon_wr_sink_if;
    import avalon_wr_sink_pkg::*;

    logic               topA_write;
    logic [ADDR_W-1:0]  topA_address;
    logic [WDATA_W-1:0] topA_writedata;
    logic               topA_waitrequest;

    modport master (
        output topA_write, topA_address, topA_writedata,
        input  topA_waitrequest
    );

    modport slave (
        input  topA_write, topA_address, topA_writedata,
        output topA_waitrequest
    );

endinterface

// File: rtl/avalon_wr_sink_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry reads as zero while empty.
module avalon_wr_sink_fifo #(
    parameter int WIDTH = 520,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the reset count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/avalon_wr_sink.sv
// Avalon-MM write sink to framed Avalon-ST stream with sop/eop policing and control window.
// Optional statistics counters are built when AVALON_WR_SINK_STATS_EN is defined.
module avalon_wr_sink
    import avalon_wr_sink_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 SoftReset,
    avalon_wr_sink_if.slave      topA,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic [EMPTY_W-1:0]   out_empty,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          stat_pkt_cnt,
    output logic [31:0]          stat_drop_cnt
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    frame_state_e     state_q, state_d;
    logic             wait_q, wait_d;
    logic             accept, is_ctrl, beat_sop, beat_eop;
    logic             push, pop, drop, ctrl_idle;
    fifo_entry_t      wr_entry, head;
    logic [CNT_W-1:0] fifo_count, count_next;
    logic             fifo_full, fifo_empty;
    logic             unused_ok;

    assign topA.topA_waitrequest = wait_q;
    assign accept    = topA.topA_write && !wait_q;
    assign is_ctrl   = topA.topA_address[CTRL_ADDR_BIT];
    assign beat_sop  = topA.topA_writedata[SOP_BIT];
    assign beat_eop  = topA.topA_writedata[EOP_BIT];
    assign ctrl_idle = accept && is_ctrl && topA.topA_writedata[CTRL_IDLE_BIT];

    always_comb begin
        wr_entry.data  = topA.topA_writedata[DATA_W-1:0];
        wr_entry.sop   = beat_sop;
        wr_entry.eop   = beat_eop;
        wr_entry.empty = beat_eop ? topA.topA_writedata[EMPTY_LSB +: EMPTY_W] : '0;
    end

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        drop    = 1'b0;
        if (accept && !is_ctrl) begin
            unique case (state_q)
                IDLE: begin
                    if (beat_sop) begin
                        push = 1'b1;
                        if (!beat_eop) state_d = IN_PKT;
                    end else begin
                        drop = 1'b1;
                    end
                end
                IN_PKT: begin
                    if (beat_sop) begin
                        drop = 1'b1;
                    end else begin
                        push = 1'b1;
                        if (beat_eop) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (ctrl_idle) state_d = IDLE;
    end

    // Back-pressure is registered from the post-edge occupancy, so a pop on a full FIFO frees space one cycle later.
    assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign wait_d     = (count_next == CNT_W'(DEPTH));

    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            state_q <= IDLE;
            wait_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    avalon_wr_sink_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (SoftReset),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = head.data;
    assign out_sop   = head.sop;
    assign out_eop   = head.eop;
    assign out_empty = head.empty;

`ifdef AVALON_WR_SINK_STATS_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic        ctrl_clr;

    assign ctrl_clr = accept && is_ctrl && topA.topA_writedata[CTRL_CLR_BIT];

    // A clear overrides any increment landing in the same cycle.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q + 32'(pop && head.eop);
        drop_cnt_d = drop_cnt_q + 32'(drop);
        if (ctrl_clr) begin
            pkt_cnt_d  = '0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge SoftReset) begin
        if (SoftReset) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign stat_pkt_cnt  = pkt_cnt_q;
    assign stat_drop_cnt = drop_cnt_q;
    assign unused_ok = &{1'b0, topA.topA_address[CTRL_ADDR_BIT-1:0],
                         topA.topA_writedata[WDATA_W-1], fifo_full};
`else
    assign stat_pkt_cnt  = '0;
    assign stat_drop_cnt = '0;
    assign unused_ok = &{1'b0, topA.topA_address[CTRL_ADDR_BIT-1:0],
                         topA.topA_writedata[WDATA_W-1], fifo_full, drop};
`endif

endmodule

// File: tb/tb_avalon_wr_sink.sv
// Self-checking bench for avalon_wr_sink: directed plan steps then random traffic against a queue model.
module tb_avalon_wr_sink;

    localparam int DEPTH = 16;

    typedef struct {
        logic [511:0] data;
        bit           sop;
        bit           eop;
        logic [5:0]   empty;
    } beat_t;

    logic         clk = 1'b0;
    logic         SoftReset = 1'b0;
    logic [511:0] out_data;
    logic         out_sop, out_eop, out_valid;
    logic         out_ready = 1'b0;
    logic [5:0]   out_empty;
    logic [31:0]  stat_pkt_cnt, stat_drop_cnt;

    avalon_wr_sink_if dif ();

    avalon_wr_sink #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .SoftReset     (SoftReset),
        .topA          (dif.slave),
        .out_data      (out_data),
        .out_sop       (out_sop),
        .out_eop       (out_eop),
        .out_empty     (out_empty),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .stat_pkt_cnt  (stat_pkt_cnt),
        .stat_drop_cnt (stat_drop_cnt)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;

    // Reference model state: buffered beats, packet-open flag, counters, expected back-pressure.
    beat_t       q[$];
    bit          in_pkt   = 1'b0;
    bit          wait_exp = 1'b1;
    logic [31:0] pkt_m    = '0;
    logic [31:0] drop_m   = '0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_pkt();
`ifdef AVALON_WR_SINK_STATS_EN
        return pkt_m;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] exp_drop();
`ifdef AVALON_WR_SINK_STATS_EN
        return drop_m;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [511:0] rand_data();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Compare outputs mid-cycle, then advance one edge and apply the write/pop rules to the model.
    task automatic cycle();
        bit           acc, pop_now, ctrl, sop, eop, legal;
        logic [520:0] wd;
        beat_t        b;
        check("waitrequest", 512'(dif.topA_waitrequest), 512'(wait_exp));
        check("out_valid", 512'(out_valid), 512'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_data", out_data, q[0].data);
            check("out_sop", 512'(out_sop), 512'(q[0].sop));
            check("out_eop", 512'(out_eop), 512'(q[0].eop));
            check("out_empty", 512'(out_empty), 512'(q[0].empty));
        end
        check("stat_pkt_cnt", 512'(stat_pkt_cnt), 512'(exp_pkt()));
        check("stat_drop_cnt", 512'(stat_drop_cnt), 512'(exp_drop()));
        acc     = dif.topA_write && !wait_exp;
        pop_now = (q.size() != 0) && out_ready;
        ctrl    = dif.topA_address[16];
        wd      = dif.topA_writedata;
        @(posedge clk);
        if (pop_now) begin
            b = q.pop_front();
            if (b.eop) pkt_m++;
        end
        if (acc && ctrl) begin
            if (wd[1]) in_pkt = 1'b0;
            if (wd[0]) begin
                pkt_m  = '0;
                drop_m = '0;
            end
        end else if (acc) begin
            sop   = wd[512];
            eop   = wd[513];
            legal = in_pkt ? !sop : sop;
            if (legal) begin
                b.data  = wd[511:0];
                b.sop   = sop;
                b.eop   = eop;
                b.empty = eop ? wd[519:514] : 6'd0;
                q.push_back(b);
                in_pkt = !eop;
            end else begin
                drop_m++;
            end
        end
        wait_exp = (q.size() == DEPTH);
        #1;
    endtask

    task automatic drive(input bit ctrl, input bit sop, input bit eop,
                         input logic [5:0] emp, input logic [511:0] data);
        dif.topA_write     = 1'b1;
        dif.topA_address   = {ctrl, 16'($urandom)};
        dif.topA_writedata = {1'($urandom), emp, eop, sop, data};
    endtask

    task automatic idle();
        dif.topA_write = 1'b0;
        cycle();
    endtask

    // Hold a write until the model says it is accepted, within a bounded number of cycles.
    task automatic write_beat(input bit ctrl, input bit sop, input bit eop,
                              input logic [5:0] emp, input logic [511:0] data);
        bit done = 1'b0;
        drive(ctrl, sop, eop, emp, data);
        for (int i = 0; i < 40 && !done; i++) begin
            done = !wait_exp;
            cycle();
        end
        check("write_accepted", 512'(done), 512'(1'b1));
        dif.topA_write = 1'b0;
    endtask

    task automatic apply_reset();
        dif.topA_write = 1'b0;
        SoftReset      = 1'b1;
        #1;
        q.delete();
        in_pkt   = 1'b0;
        pkt_m    = '0;
        drop_m   = '0;
        wait_exp = 1'b1;
        check("rst_waitrequest", 512'(dif.topA_waitrequest), 512'(1'b1));
        check("rst_out_valid", 512'(out_valid), 512'(1'b0));
        check("rst_out_data", out_data, 512'd0);
        check("rst_out_sop", 512'(out_sop), 512'(1'b0));
        check("rst_out_eop", 512'(out_eop), 512'(1'b0));
        check("rst_out_empty", 512'(out_empty), 512'(6'd0));
        check("rst_pkt_cnt", 512'(stat_pkt_cnt), 512'(32'd0));
        check("rst_drop_cnt", 512'(stat_drop_cnt), 512'(32'd0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        SoftReset = 1'b0;
        #1;
        check("release_waitrequest", 512'(dif.topA_waitrequest), 512'(1'b1));
        @(posedge clk);
        #1;
        wait_exp = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.topA_write     = 1'b0;
        dif.topA_address   = '0;
        dif.topA_writedata = '0;
        #1;
        apply_reset();

        // Three-beat packet with the downstream always ready.
        out_ready = 1'b1;
        write_beat(1'b0, 1'b1, 1'b0, 6'd17, rand_data());
        write_beat(1'b0, 1'b0, 1'b0, 6'd9,  rand_data());
        write_beat(1'b0, 1'b0, 1'b1, 6'd5,  rand_data());
        repeat (3) idle();
`ifdef AVALON_WR_SINK_STATS_EN
        check("pkt_cnt_after_3beat", 512'(stat_pkt_cnt), 512'(32'd1));
`endif

        // Fill the FIFO with the downstream stalled.
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            write_beat(1'b0, i == 0, i == DEPTH - 1, 6'(i), rand_data());
        check("wait_when_full", 512'(dif.topA_waitrequest), 512'(1'b1));
        drive(1'b0, 1'b1, 1'b1, 6'd63, rand_data());
        out_ready = 1'b1;
        check("wait_full_with_pop", 512'(dif.topA_waitrequest), 512'(1'b1));
        cycle();
        out_ready = 1'b0;
        check("wait_after_pop", 512'(dif.topA_waitrequest), 512'(1'b0));
        cycle();
        out_ready = 1'b1;
        repeat (DEPTH + 2) idle();

        // Out-of-order beats are dropped.
        write_beat(1'b0, 1'b0, 1'b1, 6'd0, rand_data());
        idle();
        check("drop_idle_no_output", 512'(out_valid), 512'(1'b0));
`ifdef AVALON_WR_SINK_STATS_EN
        check("drop_cnt_1", 512'(stat_drop_cnt), 512'(32'd1));
`endif
        write_beat(1'b0, 1'b1, 1'b0, 6'd0, rand_data());
        write_beat(1'b0, 1'b1, 1'b1, 6'd0, rand_data());
        idle();
`ifdef AVALON_WR_SINK_STATS_EN
        check("drop_cnt_2", 512'(stat_drop_cnt), 512'(32'd2));
`endif
        write_beat(1'b0, 1'b0, 1'b1, 6'd3, rand_data());
        repeat (3) idle();

        // Control write mid-packet clears counters and returns framing to IDLE.
        write_beat(1'b0, 1'b1, 1'b0, 6'd0, rand_data());
        write_beat(1'b0, 1'b0, 1'b0, 6'd0, rand_data());
        write_beat(1'b1, 1'b0, 1'b0, 6'd0, 512'h3);
        idle();
        check("ctrl_clr_pkt", 512'(stat_pkt_cnt), 512'(32'd0));
        check("ctrl_clr_drop", 512'(stat_drop_cnt), 512'(32'd0));
        write_beat(1'b0, 1'b0, 1'b1, 6'd0, rand_data());
        repeat (3) idle();

        // Reset with a partial packet buffered.
        out_ready = 1'b0;
        write_beat(1'b0, 1'b1, 1'b0, 6'd0, rand_data());
        for (int i = 0; i < 4; i++) write_beat(1'b0, 1'b0, 1'b0, 6'd0, rand_data());
        check("five_buffered", 512'(out_valid), 512'(1'b1));
        apply_reset();
        repeat (2) idle();
        out_ready = 1'b1;
        write_beat(1'b0, 1'b0, 1'b1, 6'd0, rand_data());
        repeat (2) idle();

        // Empty-field handling on single-beat and multi-beat packets.
        write_beat(1'b0, 1'b1, 1'b1, 6'd63, rand_data());
        idle();
        write_beat(1'b0, 1'b1, 1'b0, 6'd9, rand_data());
        write_beat(1'b0, 1'b0, 1'b1, 6'd2, rand_data());
        repeat (3) idle();

        // Random traffic: stalled-heavy phase, then ready-heavy phase.
        for (int i = 0; i < 600; i++) begin
            out_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 19) == 0)
                    drive(1'b1, 1'b0, 1'b0, 6'd0, 512'($urandom_range(0, 3)));
                else
                    drive(1'b0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                          6'($urandom), rand_data());
            end else begin
                dif.topA_write = 1'b0;
            end
            cycle();
        end

        out_ready = 1'b1;
        repeat (DEPTH + 2) idle();
        check("final_drained", 512'(out_valid), 512'(1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avalon_wr_sink.md
# avalon_wr_sink

Avalon-MM write sink that terminates the 17-bit-address / 521-bit-data write port driven by the active-message write service (`topA_*`) and turns accepted write beats into a framed Avalon-ST packet stream for the downstream datapath. It buffers beats in a first-word-fall-through FIFO and back-pressures the master with `waitrequest`. It also enforces sop/eop framing, dropping out-of-order beats, and takes control writes from a separate address window.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 4.
- `clk`  in  1: sole clock.
- `SoftReset`  in  1: reset, asynchronous and active-high.
- `topA_write`  in  1: write request.
- `topA_address`  in  17: bit 16 selects the control window (1) or the data window (0); bits 15:0 are ignored.
- `topA_writedata`  in  521: bits 511:0 payload; bit 512 sop; bit 513 eop; bits 519:514 empty (byte count); bit 520 reserved, ignored.
- `topA_waitrequest`  out  1: back-pressure to the master.
- `out_data`  out  512: stream payload.
- `out_sop`, `out_eop`  out  1 each: packet framing.
- `out_empty`  out  6: empty byte count.
- `out_valid`  out  1: stream valid.
- `out_ready`  in  1: downstream accept.
- `stat_pkt_cnt`  out  32: packets forwarded.
- `stat_drop_cnt`  out  32: beats dropped.

## Operation
- Accept: a write is accepted in any cycle where `topA_write && !topA_waitrequest`. Other cycles are ignored.
- `topA_waitrequest` is 1 when FIFO count == DEPTH or while reset is asserted. It is driven from registers only and never depends on `topA_write`.
- Full FIFO with a pop in the same cycle: the write is still blocked. Space is seen the following cycle.
- Data-window framing FSM, states IDLE and IN_PKT:
  - IDLE, sop=1, eop=0: push, go to IN_PKT.
  - IDLE, sop=1, eop=1: push, stay in IDLE (single-beat packet).
  - IDLE, sop=0: drop, increment drop count, stay in IDLE.
  - IN_PKT, sop=0, eop=0: push, stay in IN_PKT.
  - IN_PKT, sop=0, eop=1: push, go to IDLE.
  - IN_PKT, sop=1: drop, increment drop count, stay in IN_PKT.
- Empty field on push: stored as written when eop=1; forced to 0 when eop=0.
- Control window (address bit 16 = 1): obeys `waitrequest` and is never pushed.
  - writedata bit 0 = 1: clear both counters.
  - writedata bit 1 = 1: force the FSM to IDLE.
  - Other bits are ignored.
  - A control write does not change FIFO contents.
- Output: `out_valid` = FIFO not empty. The head entry is presented on `out_data`, `out_sop`, `out_eop`, `out_empty`. It pops when `out_valid && out_ready`.
- Packet count increments once per popped eop beat. Drop count increments once per dropped beat.
- Both counters are 32-bit and wrap modulo 2^32. A clear in the same cycle as an increment wins; the result is 0.

## Timing
- Reset values:
  - `topA_waitrequest` = 1.
  - `out_valid` = 0.
  - `out_data`, `out_sop`, `out_eop`, `out_empty` = 0.
  - Counters = 0, FSM = IDLE, FIFO empty.
- `waitrequest` falls on the first clock edge after `SoftReset` deasserts.
- Reset asserted mid-packet discards FIFO contents and the partial packet. Nothing is emitted downstream after reset.
- Latency: a beat accepted at edge N is visible on `out_valid` after edge N, i.e. presented in cycle N+1.
- Sustained throughput is one beat per cycle in and out with `out_ready`=1. Push and pop in the same cycle keep the count unchanged.
- `out_*` stay stable while `out_valid && !out_ready`.

## Configuration
- `AVALON_WR_SINK_STATS_EN` defined: packet and drop counters are implemented, and control bit 0 clears them.
- Not defined: counter logic is absent, `stat_pkt_cnt` and `stat_drop_cnt` are tied to 0, and control bit 0 is ignored. Framing, drop decisions and FIFO behaviour are identical in both builds.

## Structure
- Package `avalon_wr_sink_pkg` holds:
  - writedata bit-position constants (SOP_BIT=512, EOP_BIT=513, EMPTY_LSB=514, CTRL_ADDR_BIT=16).
  - the framing FSM state enum (IDLE, IN_PKT).
  - the packed FIFO entry struct {data[511:0], sop, eop, empty[5:0]}, 520 bits.
- Sub-module `avalon_wr_sink_fifo`: synchronous FWFT FIFO, parameterised by width and DEPTH, exposing count/full/empty. Framing, control decode and statistics stay in the top.

## Test plan
- Write a 3-beat packet (sop; none; eop with empty=5) to address 0x00000, `out_ready`=1 -> three beats out in order, last beat has empty=5, `stat_pkt_cnt`=1.
- Hold `out_ready`=0 and write 16 beats -> `waitrequest`=1 after the 16th accept. Raise `out_ready` for one cycle -> `waitrequest` still 1 that cycle, 0 the next.
- In IDLE write sop=0 -> beat dropped, `stat_drop_cnt`=1, `out_valid` stays 0. In IN_PKT write sop=1 -> dropped, `stat_drop_cnt`=2.
- Write address 0x10000 with data 0x3 mid-packet -> counters = 0, FSM returns to IDLE, and the next sop=0 beat is dropped.
- Assert `SoftReset` with 5 beats buffered -> `out_valid`=0 and `waitrequest`=1 immediately. After release, `waitrequest`=0 next edge and the FIFO is empty.
- Single-beat packet sop=eop=1 with empty=63 -> one output beat, empty=63. A non-eop beat written with empty=9 emits empty=0.
